// File: rtl/am2940_dmactl.sv
// Controller-side sequencer for an am2940 DMA address generator: programs CR/AR/WC, runs dreq/dack transfers, signals end of block.
// Define DMA_AUTOINIT_EN to widen cfg_cr to 4 bits and enable the bit3 auto-init (REINIT and repeat) loop.
module am2940_dmactl #(
  parameter int W = 8
) (
  input  logic         cp,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
`ifdef DMA_AUTOINIT_EN
  input  logic [3:0]   cfg_cr,
`else
  input  logic [2:0]   cfg_cr,
`endif
  input  logic [W-1:0] cfg_ar,
  input  logic [W-1:0] cfg_wc,
  input  logic         dreq,
  output logic         dack,
  output logic [2:0]   i,
  output logic [W-1:0] dout,
  output logic         doe,
  output logic         aci_,
  output logic         wci_,
  output logic         oea_,
  input  logic         done,
  input  logic         wco_,
  output logic         busy,
  output logic         irq,
  output logic         aborted,
  output logic [W-1:0] xfer_cnt
);

  localparam int CR_W = $bits(cfg_cr);

  typedef enum logic [2:0] {IDLE, WRCR, LDAR, LDWC, WAIT, XFER, FIN} state_t;

  state_t          state, state_nx;
  logic [CR_W-1:0] cr_q, cr_src;
  logic [W-1:0]    ar_q, wc_q;
  logic [1:0]      mode;
  logic            autoinit, last;
  logic            aborted_nx, doe_nx, aci_nx, wci_nx, oea_nx, dack_nx, busy_nx, irq_nx;
  logic [2:0]      i_nx;
  logic [W-1:0]    dout_nx, cnt_nx;

  assign mode = cr_q[1:0];
  // WRCR is entered straight from IDLE, before cr_q has been loaded
  assign cr_src = (state == IDLE) ? cfg_cr : cr_q;

`ifdef DMA_AUTOINIT_EN
  assign autoinit = cr_q[3];
`else
  assign autoinit = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    aborted_nx = aborted;
    cnt_nx     = xfer_cnt;
    last       = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx   = WRCR;
        aborted_nx = 1'b0;
        cnt_nx     = '0;
      end
      WRCR, LDAR, LDWC: begin
        if (abort) begin
          state_nx   = FIN;
          aborted_nx = 1'b1;
        end else begin
          state_nx = (state == WRCR) ? LDAR : (state == LDAR) ? LDWC : WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_nx   = FIN;
          aborted_nx = 1'b1;
        end else if (mode == 2'd1 && done) begin
          state_nx = FIN;
        end else if (dreq) begin
          state_nx = XFER;
        end
      end
      XFER: begin
        // done/wco_ reflect the am2940 counters before this cycle's count edge
        cnt_nx = xfer_cnt + 1'b1;
        last   = (mode == 2'd3) ? !wco_ : (mode != 2'd1) && done;
        if (last) begin
          state_nx = FIN;
        end else if (abort) begin
          state_nx   = FIN;
          aborted_nx = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      FIN: begin
        if (autoinit && !aborted) begin
          state_nx = WAIT;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    i_nx    = 3'b111;
    dout_nx = '0;
    doe_nx  = 1'b0;
    aci_nx  = 1'b1;
    wci_nx  = 1'b1;
    oea_nx  = 1'b1;
    dack_nx = 1'b0;
    irq_nx  = 1'b0;
    busy_nx = (state_nx != IDLE);
    case (state_nx)
      WRCR: begin i_nx = 3'b000; dout_nx = W'(cr_src); doe_nx = 1'b1; end
      LDAR: begin i_nx = 3'b101; dout_nx = ar_q;       doe_nx = 1'b1; end
      LDWC: begin i_nx = 3'b110; dout_nx = wc_q;       doe_nx = 1'b1; end
      WAIT: oea_nx = 1'b0;
      XFER: begin aci_nx = 1'b0; wci_nx = 1'b0; oea_nx = 1'b0; dack_nx = 1'b1; end
      FIN: begin
        irq_nx = 1'b1;
        if (autoinit && !aborted_nx) i_nx = 3'b100;
      end
      default: ;
    endcase
  end

  always_ff @(posedge cp) begin
    if (rst) begin
      state    <= IDLE;
      i        <= 3'b111;
      dout     <= '0;
      doe      <= 1'b0;
      aci_     <= 1'b1;
      wci_     <= 1'b1;
      oea_     <= 1'b1;
      dack     <= 1'b0;
      busy     <= 1'b0;
      irq      <= 1'b0;
      aborted  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      state    <= state_nx;
      i        <= i_nx;
      dout     <= dout_nx;
      doe      <= doe_nx;
      aci_     <= aci_nx;
      wci_     <= wci_nx;
      oea_     <= oea_nx;
      dack     <= dack_nx;
      busy     <= busy_nx;
      irq      <= irq_nx;
      aborted  <= aborted_nx;
      xfer_cnt <= cnt_nx;
    end
  end

  always_ff @(posedge cp) begin
    if (state == IDLE && start) begin
      cr_q <= cfg_cr;
      ar_q <= cfg_ar;
      wc_q <= cfg_wc;
    end
  end

endmodule

// File: tb/tb_am2940_dmactl.sv
// Bench for am2940_dmactl: attached am2940 model, random blocks, and a scoreboard of expected addresses and block results.
module tb_am2940_dmactl;
`ifdef DMA_AUTOINIT_EN
  localparam int CR_W = 4;
`else
  localparam int CR_W = 3;
`endif

  logic cp = 1'b0;
  always #5 cp = ~cp;

  logic rst = 1'b1, start = 1'b0, abort = 1'b0, dreq = 1'b0, done, wco_;
  logic [CR_W-1:0] cfg_cr = '0;
  logic [7:0] cfg_ar = '0, cfg_wc = '0;
  logic dack, doe, aci_, wci_, oea_, busy, irq, aborted;
  logic [2:0] i;
  logic [7:0] dout, xfer_cnt;

  am2940_dmactl #(.W(8)) dut (
    .cp(cp), .rst(rst), .start(start), .abort(abort), .cfg_cr(cfg_cr), .cfg_ar(cfg_ar),
    .cfg_wc(cfg_wc), .dreq(dreq), .dack(dack), .i(i), .dout(dout), .doe(doe), .aci_(aci_),
    .wci_(wci_), .oea_(oea_), .done(done), .wco_(wco_), .busy(busy), .irq(irq),
    .aborted(aborted), .xfer_cnt(xfer_cnt)
  );

  int checks = 0, failures = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // am2940 device model
  logic [2:0] m_cr = '0;
  logic [7:0] m_ar = '0, m_acc = '0, m_wcr = '0, m_wcc = '0;
  always @(posedge cp) begin
    case (i)
      3'b000: m_cr <= dout[2:0];
      3'b101: begin m_ar <= dout; m_acc <= dout; end
      3'b110: begin m_wcr <= dout; m_wcc <= (m_cr[1:0] == 2'd1) ? 8'd0 : dout; end
      3'b100: begin m_acc <= m_ar; m_wcc <= (m_cr[1:0] == 2'd1) ? 8'd0 : m_wcr; end
      3'b111: begin
        if (!aci_) m_acc <= m_cr[2] ? m_acc - 8'd1 : m_acc + 8'd1;
        if (!wci_) m_wcc <= m_cr[0] ? m_wcc + 8'd1 : m_wcc - 8'd1;
      end
      default: ;
    endcase
  end
  always_comb begin
    case (m_cr[1:0])
      2'd0:    done = (m_wcc == 8'd1);
      2'd1:    done = (m_wcc == m_wcr);
      2'd2:    done = (m_acc == m_wcr);
      default: done = (m_wcc == 8'hFF);
    endcase
    wco_ = !(m_wcc == 8'hFF);
  end

  // Reference: number of transfers a block performs, from the mode rules
  function automatic int exp_n(input logic [2:0] cr, input logic [7:0] ar, input logic [7:0] wc);
    logic [7:0] d;
    d = cr[2] ? ar - wc : wc - ar;
    case (cr[1:0])
      2'd0:    return (wc == 8'd0) ? 256 : int'(wc);
      2'd1:    return int'(wc);
      2'd2:    return int'(d) + 1;
      default: return 256 - int'(wc);
    endcase
  endfunction

  typedef struct { int n; bit ab; bit reinit; } blk_t;
  blk_t exp_blk[$];
  logic [7:0] exp_addr[$];

  int cyc = 0, last_dack = 0, blk_seen = 0;
  bit hold_dreq = 1'b0;
  always @(posedge cp) cyc <= cyc + 1;

  always @(negedge cp) begin
    blk_t b;
    if (rst) begin
      blk_seen <= 0;
    end else begin
      if (dack) begin
        if (exp_addr.size() == 0) check("unexpected_dack", 32'd1, 32'd0);
        else check("xfer_addr", m_acc, exp_addr.pop_front());
        check("xfer_strobes", {i, aci_, wci_, oea_}, {3'b111, 3'b000});
        if (hold_dreq && blk_seen > 0) check("throughput_gap", cyc - last_dack, 2);
        last_dack <= cyc;
        blk_seen  <= blk_seen + 1;
      end
      if (irq) begin
        if (exp_blk.size() == 0) check("unexpected_irq", 32'd1, 32'd0);
        else begin
          b = exp_blk.pop_front();
          check("blk_xfer_cnt", xfer_cnt, b.n);
          check("blk_dacks", blk_seen, b.n);
          check("blk_aborted", aborted, b.ab);
          check("fin_i_busy", {i, busy}, {(b.reinit ? 3'b100 : 3'b111), 1'b1});
        end
        blk_seen <= 0;
      end
    end
  end

  task automatic chk_reset(input string nm);
    check({nm, "_ctl"}, {i, aci_, wci_, oea_, dack, doe, busy, irq, aborted},
          {3'b111, 3'b111, 5'b00000});
    check({nm, "_data"}, {dout, xfer_cnt}, 16'h0000);
  endtask

  task automatic run_block(input logic [CR_W-1:0] cr, input logic [7:0] ar, input logic [7:0] wc,
                           input bit hold, input int ab_after, input bit extra_start);
    int n, m, dk, cyc_b;
    bit wait_ab;
    blk_t bb;
    n = exp_n(cr[2:0], ar, wc);
    m = (ab_after >= 0 && ab_after < n) ? ab_after : n;
    for (int j = 0; j < m; j++) exp_addr.push_back(cr[2] ? ar - 8'(j) : ar + 8'(j));
    bb.n = m; bb.ab = (m < n); bb.reinit = 1'b0;
    exp_blk.push_back(bb);
    hold_dreq = hold;
    @(negedge cp);
    cfg_cr = cr; cfg_ar = ar; cfg_wc = wc; start = 1'b1; dreq = hold;
    @(negedge cp);
    start = 1'b0;
    check("wrcr_cycle", {i, dout, doe, busy, aborted}, {3'b000, 8'(cr), 3'b110});
    cfg_cr = CR_W'($urandom) & CR_W'(3'b111); cfg_ar = 8'($urandom); cfg_wc = 8'($urandom);
    dk = 0; cyc_b = 0; wait_ab = 1'b0;
    while (busy && cyc_b < 2000) begin
      if (dack) dk++;
      if (ab_after >= 0 && dk >= ab_after) begin
        dreq = 1'b0;
        if (wait_ab) abort = 1'b1;
        wait_ab = 1'b1;
      end else if (!hold) begin
        dreq = 1'($urandom);
      end
      start = (extra_start && cyc_b == 3);
      @(negedge cp);
      cyc_b++;
    end
    start = 1'b0; abort = 1'b0; dreq = 1'b0; hold_dreq = 1'b0;
    check("block_ended", busy, 1'b0);
    check("addr_left", exp_addr.size(), 0);
    check("blk_left", exp_blk.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge cp);
    chk_reset("reset");
    rst = 1'b0;

    run_block(CR_W'(3'b000), 8'h08, 8'd3, 1'b1, -1, 1'b0);
    check("mode0_final_addr", m_acc, 8'h0B);
    run_block(CR_W'(3'b110), 8'h08, 8'h05, 1'b0, -1, 1'b1);
    run_block(CR_W'(3'b011), 8'h10, 8'hFC, 1'b1, -1, 1'b0);
    run_block(CR_W'(3'b001), 8'h50, 8'd3, 1'b1, -1, 1'b0);
    run_block(CR_W'(3'b101), 8'h50, 8'd0, 1'b1, -1, 1'b0);
    run_block(CR_W'(3'b000), 8'h30, 8'd10, 1'b0, 2, 1'b0);
    check("aborted_held", aborted, 1'b1);
    run_block(CR_W'(3'b010), 8'h60, 8'h64, 1'b0, 0, 1'b0);

    // reset in the middle of a transfer
    for (int j = 0; j < 5; j++) exp_addr.push_back(8'h20 + 8'(j));
    hold_dreq = 1'b1;
    @(negedge cp);
    cfg_cr = '0; cfg_ar = 8'h20; cfg_wc = 8'd5; start = 1'b1; dreq = 1'b1;
    @(negedge cp);
    start = 1'b0;
    for (int c = 0; c < 50 && !dack; c++) @(negedge cp);
    check("rst_dack_seen", dack, 1'b1);
    rst = 1'b1;
    @(negedge cp);
    chk_reset("rst_mid_xfer");
    rst = 1'b0; dreq = 1'b0; hold_dreq = 1'b0;
    exp_addr.delete(); exp_blk.delete();

`ifdef DMA_AUTOINIT_EN
    begin
      int dk, c;
      blk_t bb;
      for (int k = 0; k < 2; k++) begin
        exp_addr.push_back(8'h40); exp_addr.push_back(8'h41);
        bb.n = 2; bb.ab = 1'b0; bb.reinit = 1'b1; exp_blk.push_back(bb);
      end
      bb.n = 0; bb.ab = 1'b1; bb.reinit = 1'b0; exp_blk.push_back(bb);
      @(negedge cp);
      cfg_cr = 4'b1000; cfg_ar = 8'h40; cfg_wc = 8'd2; start = 1'b1; dreq = 1'b1;
      @(negedge cp);
      start = 1'b0;
      dk = 0; c = 0;
      while (dk < 4 && c < 200) begin
        @(negedge cp);
        c++;
        if (dack) dk++;
      end
      dreq = 1'b0;
      check("ai_dacks", dk, 4);
      repeat (4) @(negedge cp);
      check("ai_busy_loop", busy, 1'b1);
      abort = 1'b1;
      for (int k = 0; k < 20 && busy; k++) @(negedge cp);
      abort = 1'b0;
      check("ai_ended", busy, 1'b0);
      check("ai_addr_left", exp_addr.size(), 0);
      check("ai_blk_left", exp_blk.size(), 0);
    end
`endif

    for (int k = 0; k < 24; k++) begin
      logic [2:0] c;
      logic [7:0] a, w;
      int n, ab;
      c = 3'($urandom);
      a = 8'($urandom);
      case (c[1:0])
        2'd0:    w = 8'($urandom_range(1, 10));
        2'd1:    w = 8'($urandom_range(0, 8));
        2'd2:    w = c[2] ? a - 8'($urandom_range(0, 8)) : a + 8'($urandom_range(0, 8));
        default: w = 8'hFF - 8'($urandom_range(0, 8));
      endcase
      n = exp_n(c, a, w);
      ab = ($urandom_range(0, 3) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_block(CR_W'(c), a, w, ($urandom_range(0, 1) == 1) && ab < 0, ab, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
